// File: rtl/rt_fifo_arb_pkg.sv
// Shared types and constants for the round-robin Fifo write arbiter.
// Optional statistics counters are enabled by defining FIFO_ARB_STATS_EN.
package rt_fifo_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

   localparam int unsigned STAT_W = 16;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// Combinational round-robin picker: rotate req so rr_ptr sits at bit 0,
// find the first set bit, then rotate the index back.
module rr_priority_picker #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [IDX_W-1:0]     ofs;
   logic [IDX_W:0]       sum;

   always_comb begin
      dbl = {req, req} >> rr_ptr;
      rot = dbl[NUM_REQ-1:0];
      any = |rot;
      ofs = '0;
      // scan downwards so the lowest set bit is the last one written
      for (int unsigned k = NUM_REQ; k > 0; k--) begin
         if (rot[k-1]) ofs = IDX_W'(k - 1);
      end
      sum = {1'b0, rr_ptr} + {1'b0, ofs};
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      gnt = '0;
      if (any) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one Fifo write port between NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add grant_count / stall_cycles counter ports.
module fifo_write_arbiter
   import rt_fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              grant,
   output logic                            fifo_wr_en,
   output logic [WIDTH-1:0]                fifo_wr_data,
   input  logic                            fifo_full,
   input  logic                            fifo_almost_full
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ-1:0][STAT_W-1:0]  grant_count,
   output logic [STAT_W-1:0]               stall_cycles
`endif
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_t         state_q, state_d;
   logic               out_valid, can_grant, take, pick_any;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx, rr_ptr;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr),
      .gnt    (pick_gnt),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      out_valid = (state_q == ARB_HOLD);
      can_grant = pick_any & ~fifo_almost_full & ~rst;
      state_d   = state_q;
      take      = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (can_grant) begin
               take    = 1'b1;
               state_d = ARB_HOLD;
            end
         end
         ARB_HOLD: begin
            if (!fifo_full) begin
               if (can_grant) take = 1'b1;
               else           state_d = ARB_IDLE;
            end
         end
      endcase
      grant = take ? pick_gnt : '0;
      // a word still held when rst is sampled must never reach the Fifo
      fifo_wr_en = out_valid & ~fifo_full & ~rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         fifo_wr_data <= '0;
         rr_ptr       <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            fifo_wr_data <= req_data[pick_idx];
            rr_ptr       <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
         end
      end
   end

`ifdef FIFO_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_count  <= '0;
         stall_cycles <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_count[i] <= sat_inc(grant_count[i]);
         end
         if (out_valid & fifo_full) stall_cycles <= sat_inc(stall_cycles);
      end
   end
`else
   // no statistics counters in this build
`endif

endmodule
